// File: rtl/md5_pad_strm.sv
// RFC 1321 padding stage for the MD5 streaming core: turns a raw message arriving as
// 512-bit beats into whole padded chunks, the last one carrying the bit length.
typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [63:0] data;
} softreg_req_t;

typedef struct packed {
    logic        valid;
    logic [63:0] data;
} softreg_resp_t;

module md5_pad_strm #(
    parameter int DATA_W = 512,
    parameter int ID_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  softreg_req_t      softreg_req,
    output softreg_resp_t     softreg_resp,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [ID_W-1:0]   m_tid,
    output logic              m_tlast
);
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_PAD  = 3'd2,
        ST_DONE = 3'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [60:0]       len_r;
    logic [5:0]        rem_r;
    logic [55:0]       beats_r;
    logic [63:0]       chunks_r;
    logic [ID_W-1:0]   id_r;
    logic              m_tvalid_r;
    logic              m_tlast_r;
    logic [DATA_W-1:0] m_tdata_r;
    logic [ID_W-1:0]   m_tid_r;
    logic              resp_valid_r;
    logic [63:0]       resp_data_r;

    logic              wr_s;
    logic              rd_s;
    logic              start_s;
    logic              id_wr_s;
    logic              out_free_s;
    logic              s_hs_s;
    logic              m_hs_s;
    logic              load_s;
    logic              last_s;
    logic              s_tready_s;
    logic [55:0]       beats_init_s;
    logic [63:0]       len_bits_s;
    logic [DATA_W-1:0] tail_s;
    logic [DATA_W-1:0] chunk_s;
    logic              rd_hit_s;
    logic [63:0]       rd_data_s;

    assign wr_s         = softreg_req.valid && softreg_req.is_write;
    assign rd_s         = softreg_req.valid && !softreg_req.is_write;
    assign start_s      = wr_s && (softreg_req.addr == 32'h0000_0000) && (state_r == ST_IDLE);
    assign id_wr_s      = wr_s && (softreg_req.addr == 32'h0000_0008);
    assign beats_init_s = {1'b0, softreg_req.data[60:6]} + {55'd0, |softreg_req.data[5:0]};
    assign len_bits_s   = {len_r, 3'b000};
    assign out_free_s   = !m_tvalid_r || m_tready;
    assign s_hs_s       = s_tvalid && s_tready_s;
    assign m_hs_s       = m_tvalid_r && m_tready;

    assign s_tready          = s_tready_s;
    assign m_tvalid          = m_tvalid_r;
    assign m_tdata           = m_tdata_r;
    assign m_tid             = m_tid_r;
    assign m_tlast           = m_tlast_r;
    assign softreg_resp.valid = resp_valid_r;
    assign softreg_resp.data  = resp_data_r;

    // Final partial beat: keep bytes below r, put the 0x80 marker at r, zero the rest
    always_comb begin
        tail_s = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (6'(i) < rem_r) begin
                tail_s[8*i +: 8] = s_tdata[8*i +: 8];
            end else if (6'(i) == rem_r) begin
                tail_s[8*i +: 8] = 8'h80;
            end else begin
                tail_s[8*i +: 8] = 8'h00;
            end
        end
    end

    // Next state, input ready and the chunk to load into the output register
    always_comb begin
        state_nxt_s = state_r;
        s_tready_s  = 1'b0;
        load_s      = 1'b0;
        last_s      = 1'b0;
        chunk_s     = s_tdata;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (beats_init_s != 56'd0) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_PAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                s_tready_s = (beats_r != 56'd0) && out_free_s;
                if (s_tvalid && s_tready_s) begin
                    load_s = 1'b1;
                    if (beats_r != 56'd1) begin
                        chunk_s = s_tdata;
                    end else if (rem_r == 6'd0) begin
                        chunk_s     = s_tdata;
                        state_nxt_s = ST_PAD;
                    end else if (rem_r <= 6'd55) begin
                        // Marker and length both fit in the final beat
                        chunk_s     = {len_bits_s, tail_s[DATA_W-65:0]};
                        last_s      = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        chunk_s     = tail_s;
                        state_nxt_s = ST_PAD;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PAD: begin
                if (out_free_s) begin
                    load_s      = 1'b1;
                    last_s      = 1'b1;
                    chunk_s     = {len_bits_s, {(DATA_W-72){1'b0}},
                                   ((rem_r == 6'd0) ? 8'h80 : 8'h00)};
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_PAD;
                end
            end
            ST_DONE: begin
                if (m_hs_s && m_tlast_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Register read mux; unmapped addresses leave the response data untouched
    always_comb begin
        rd_hit_s  = 1'b1;
        rd_data_s = 64'd0;
        case (softreg_req.addr)
            32'h0000_0010: rd_data_s = chunks_r;
            32'h0000_0018: rd_data_s = {61'd0, state_r};
            32'h0000_0020: rd_data_s = {8'd0, beats_r};
            default:       rd_hit_s  = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Message context: latched length, tail byte count and beats still to accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_r   <= 61'd0;
            rem_r   <= 6'd0;
            beats_r <= 56'd0;
        end else if (start_s) begin
            len_r   <= softreg_req.data[60:0];
            rem_r   <= softreg_req.data[5:0];
            beats_r <= beats_init_s;
        end else if (s_hs_s) begin
            beats_r <= beats_r - 56'd1;
        end
    end

    // Chunk counter and ID register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chunks_r <= 64'd0;
            id_r     <= '0;
        end else begin
            if (start_s) begin
                chunks_r <= 64'd0;
            end else if (m_hs_s) begin
                chunks_r <= chunks_r + 64'd1;
            end
            if (id_wr_s) begin
                id_r <= softreg_req.data[ID_W-1:0];
            end
        end
    end

    // Single-stage output register, held while the consumer stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            m_tdata_r  <= '0;
            m_tid_r    <= '0;
        end else if (load_s) begin
            m_tvalid_r <= 1'b1;
            m_tlast_r  <= last_s;
            m_tdata_r  <= chunk_s;
            m_tid_r    <= id_r;
        end else if (m_tready) begin
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
        end
    end

    // Register read response, one cycle after the request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_r <= 1'b0;
            resp_data_r  <= 64'd0;
        end else begin
            resp_valid_r <= rd_s;
            if (rd_s && rd_hit_s) begin
                resp_data_r <= rd_data_s;
            end
        end
    end

endmodule
